// File: rtl/arith_enc_pkg.sv
// Shared types and default sizes for the arithmetic-encoder pipeline controller.
package arith_enc_pkg;

   localparam int unsigned PIPE_DEPTH_DEF = 3;
   localparam int unsigned CNT_WIDTH_DEF  = 16;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      DRAIN,
      FLUSH,
      DONE
   } enc_state_e;

endpackage

// File: rtl/pipe_valid_tracker.sv
// Per-bank valid shift register with stall-on-backpressure load enables.
module pipe_valid_tracker #(
   parameter int unsigned PIPE_DEPTH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  accept_i,
   input  logic                  out_ready_i,
   output logic                  advance_o,
   output logic [PIPE_DEPTH-1:0] stage_en_o,
   output logic [PIPE_DEPTH-1:0] stage_vld_o,
   output logic [PIPE_DEPTH-1:0] vld_next_o
);

   logic [PIPE_DEPTH-1:0] vld_q, vld_d;

   // The whole pipe moves together or freezes together; no bubble collapsing.
   always_comb begin
      advance_o     = !vld_q[PIPE_DEPTH-1] || out_ready_i;
      stage_en_o    = '0;
      vld_d         = vld_q;
      stage_en_o[0] = accept_i;
      if (advance_o) vld_d[0] = accept_i;
      for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
         stage_en_o[k] = advance_o && vld_q[k-1];
         if (advance_o) vld_d[k] = vld_q[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= vld_d;
   end

   assign stage_vld_o = vld_q;
   assign vld_next_o  = vld_d;

endmodule

// File: rtl/arith_enc_pipe_ctrl.sv
// Frame sequencing for the arithmetic-encoder pipe: intake, drain, flush handshake
// and delivered-symbol counting.
module arith_enc_pipe_ctrl
   import arith_enc_pkg::*;
#(
   parameter int unsigned PIPE_DEPTH = PIPE_DEPTH_DEF,
   parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid_i,
   input  logic                  in_last_i,
   output logic                  in_ready_o,
   output logic [PIPE_DEPTH-1:0] stage_en_o,
   output logic [PIPE_DEPTH-1:0] stage_vld_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  flush_start_o,
   input  logic                  flush_done_i,
   output logic                  busy_o,
   output logic                  frame_done_o,
   output logic [CNT_WIDTH-1:0]  sym_count_o
);

   enc_state_e            state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  flush_start_q, flush_start_d;
   logic                  frame_done_q, frame_done_d;
   logic                  busy_q, busy_d;
   logic                  advance, accept, transfer, cnt_clr;
   logic [PIPE_DEPTH-1:0] vld_next;

   pipe_valid_tracker #(
      .PIPE_DEPTH(PIPE_DEPTH)
   ) u_trk (
      .clk        (clk),
      .rst_n      (rst_n),
      .accept_i   (accept),
      .out_ready_i(out_ready_i),
      .advance_o  (advance),
      .stage_en_o (stage_en_o),
      .stage_vld_o(stage_vld_o),
      .vld_next_o (vld_next)
   );

   assign in_ready_o  = advance && (state_q == IDLE || state_q == RUN);
   assign accept      = in_valid_i && in_ready_o;
   assign out_valid_o = stage_vld_o[PIPE_DEPTH-1];
   assign transfer    = out_valid_o && out_ready_i;

   // Drain ends on the cycle the last bank empties, so FLUSH starts right after it.
   always_comb begin
      state_d = state_q;
      cnt_clr = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_clr = 1'b1;
               state_d = in_last_i ? DRAIN : RUN;
            end
         end
         RUN:     if (accept && in_last_i) state_d = DRAIN;
         DRAIN:   if (vld_next == '0)      state_d = FLUSH;
         FLUSH:   if (flush_done_i)        state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      flush_start_d = (state_d == FLUSH) && (state_q != FLUSH);
      frame_done_d  = (state_d == DONE);
      busy_d        = (state_d != IDLE);
   end

   // Saturating delivered-symbol counter, cleared when a new frame opens.
   always_comb begin
      cnt_d = cnt_clr ? '0 : cnt_q;
      if (transfer && (cnt_d != '1)) cnt_d = cnt_d + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         flush_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         flush_start_q <= flush_start_d;
         frame_done_q  <= frame_done_d;
         busy_q        <= busy_d;
      end
   end

   assign flush_start_o = flush_start_q;
   assign frame_done_o  = frame_done_q;
   assign busy_o        = busy_q;
   assign sym_count_o   = cnt_q;

endmodule

// File: tb/tb_arith_enc_pipe_ctrl.sv
// Randomized scoreboard bench for arith_enc_pipe_ctrl (16-bit and 2-bit counter instances).
module tb_arith_enc_pipe_ctrl;
   import arith_enc_pkg::*;

   localparam int unsigned D = PIPE_DEPTH_DEF;
   localparam int MAX1 = (1 << CNT_WIDTH_DEF) - 1;

   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0, flush_done = 1'b0;

   logic         in_ready_o, out_valid_o, flush_start_o, busy_o, frame_done_o;
   logic [D-1:0] stage_en_o, stage_vld_o;
   logic [15:0]  sym_count_o;
   logic         in_ready2, out_valid2, flush_start2, busy2, frame_done2;
   logic [D-1:0] stage_en2, stage_vld2;
   logic [1:0]   sym_count2;

   arith_enc_pipe_ctrl #(.PIPE_DEPTH(D), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_last_i(in_last),
      .in_ready_o(in_ready_o), .stage_en_o(stage_en_o), .stage_vld_o(stage_vld_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready), .flush_start_o(flush_start_o),
      .flush_done_i(flush_done), .busy_o(busy_o), .frame_done_o(frame_done_o),
      .sym_count_o(sym_count_o));

   arith_enc_pipe_ctrl #(.PIPE_DEPTH(D), .CNT_WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_last_i(in_last),
      .in_ready_o(in_ready2), .stage_en_o(stage_en2), .stage_vld_o(stage_vld2),
      .out_valid_o(out_valid2), .out_ready_i(out_ready), .flush_start_o(flush_start2),
      .flush_done_i(flush_done), .busy_o(busy2), .frame_done_o(frame_done2),
      .sym_count_o(sym_count2));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: in-flight symbols tagged with accept cycle and stall count;
   // a symbol sits in bank (age-1), where age excludes cycles the pipe was frozen.
   typedef struct { int c; int st; } ent_t;
   typedef enum int {P_OPEN, P_DRAIN, P_FLUSH, P_DONE} phase_t;

   ent_t         q[$];
   ent_t         e;
   phase_t       phase = P_OPEN, np;
   bit           started = 1'b0, fs_pend = 1'b0;
   int           cnt = 0, cnt2 = 0, stalls = 0, age;
   logic [D-1:0] ev, een;
   logic         eov, eadv, erdy, eacc;

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         phase = P_OPEN; started = 1'b0; fs_pend = 1'b0;
         cnt = 0; cnt2 = 0; stalls = 0;
      end else begin
         ev = '0;
         foreach (q[i]) begin
            age = cyc - q[i].c - (stalls - q[i].st);
            if (age >= 1 && age <= int'(D)) ev[age-1] = 1'b1;
         end
         eov  = ev[D-1];
         eadv = !eov || out_ready;
         erdy = eadv && (phase == P_OPEN);
         eacc = in_valid && erdy;
         een  = '0;
         een[0] = eacc;
         for (int k = 1; k < int'(D); k++) een[k] = eadv && ev[k-1];

         chk("in_ready",    int'(in_ready_o),    int'(erdy));
         chk("stage_en",    int'(stage_en_o),    int'(een));
         chk("stage_vld",   int'(stage_vld_o),   int'(ev));
         chk("out_valid",   int'(out_valid_o),   int'(eov));
         chk("flush_start", int'(flush_start_o), int'(fs_pend));
         chk("frame_done",  int'(frame_done_o),  int'(phase == P_DONE));
         chk("busy",        int'(busy_o),        int'(started || phase != P_OPEN));
         chk("sym_count",   int'(sym_count_o),   cnt);
         chk("in_ready_w2",  int'(in_ready2),  int'(erdy));
         chk("stage_vld_w2", int'(stage_vld2), int'(ev));
         chk("busy_w2",      int'(busy2),      int'(started || phase != P_OPEN));
         chk("sym_count_w2", int'(sym_count2), cnt2);

         np = phase;
         if (out_valid_o && out_ready) begin
            if (q.size() == 0) chk("transfer_with_empty_model", q.size(), 1);
            else begin
               e = q.pop_front();
               chk("latency", cyc - e.c - (stalls - e.st), int'(D));
               if (cnt < MAX1) cnt++;
               if (cnt2 < 3) cnt2++;
               if (q.size() == 0 && phase == P_DRAIN) np = P_FLUSH;
            end
         end else if (eov) stalls++;

         fs_pend = (np == P_FLUSH) && (phase == P_DRAIN);
         if (phase == P_FLUSH && flush_done) np = P_DONE;
         if (phase == P_DONE) begin np = P_OPEN; started = 1'b0; end
         if (eacc) begin
            if (!started) begin cnt = 0; cnt2 = 0; end
            started = 1'b1;
            q.push_back('{cyc, stalls});
            if (in_last) np = P_DRAIN;
         end
         phase = np;
      end
   end

   task automatic wait_done(input int pr, input int pf, output int fs_c, output int fd_c);
      bit seen = 1'b0;
      fs_c = -1; fd_c = -1;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(posedge clk); #1;
         in_valid   = 1'($urandom_range(1));
         in_last    = 1'($urandom_range(1));
         out_ready  = ($urandom_range(99) < pr);
         flush_done = ($urandom_range(99) < pf);
         @(negedge clk);
         if (flush_start_o) fs_c = cyc;
         if (frame_done_o) begin fd_c = cyc; seen = 1'b1; end
      end
      chk("frame_done_seen", int'(seen), 1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic run_frame(input int n, input int pv, input int pr, input int pf,
                            output int t0, output int fs_c, output int fd_c);
      int sent = 0;
      int guard = 0;
      t0 = -1;
      while (sent < n && guard < 400) begin
         @(posedge clk); #1;
         in_valid   = ($urandom_range(99) < pv);
         in_last    = in_valid ? (sent == n - 1) : 1'($urandom_range(1));
         out_ready  = ($urandom_range(99) < pr);
         flush_done = ($urandom_range(99) < pf);
         @(negedge clk);
         if (in_valid && in_ready_o) begin
            if (sent == 0) t0 = cyc;
            sent++;
         end
         guard++;
      end
      chk("accepted_symbols", sent, n);
      wait_done(pr, pf, fs_c, fd_c);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"},    int'(in_ready_o),    1);
      chk({tag, "_stage_en"},    int'(stage_en_o),    0);
      chk({tag, "_stage_vld"},   int'(stage_vld_o),   0);
      chk({tag, "_out_valid"},   int'(out_valid_o),   0);
      chk({tag, "_flush_start"}, int'(flush_start_o), 0);
      chk({tag, "_frame_done"},  int'(frame_done_o),  0);
      chk({tag, "_busy"},        int'(busy_o),        0);
      chk({tag, "_sym_count"},   int'(sym_count_o),   0);
      chk({tag, "_sym_count_w2"}, int'(sym_count2),   0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int t0, fs, fd;
      #2;
      chk_reset_outputs("por");
      @(posedge clk); #2 rst_n = 1'b1;

      // 8 back-to-back symbols, no stalls
      run_frame(8, 100, 100, 100, t0, fs, fd);
      chk("stream_flush_start_cycle", fs - t0, 11);
      chk("stream_frame_done_cycle",  fd - t0, 12);
      chk("stream_sym_count",    int'(sym_count_o), 8);
      chk("stream_sym_count_w2", int'(sym_count2),  3);

      // two-cycle packer stall with all banks full
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1; flush_done = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         out_ready = 1'b0;
         @(negedge clk);
         chk("stall_vld",       int'(stage_vld_o), 7);
         chk("stall_in_ready",  int'(in_ready_o),  0);
         chk("stall_stage_en",  int'(stage_en_o),  0);
         chk("stall_sym_count", int'(sym_count_o), 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1; in_last = 1'b1;
      @(negedge clk);
      chk("stall_release_accept", int'(in_ready_o), 1);
      wait_done(100, 50, fs, fd);
      chk("stall_sym_count_final", int'(sym_count_o), 4);

      // minimum one-symbol frame, flush_done returned with flush_start
      run_frame(1, 100, 100, 100, t0, fs, fd);
      chk("single_flush_start_cycle", fs - t0, 4);
      chk("single_frame_done_cycle",  fd - t0, 5);
      chk("single_sym_count", int'(sym_count_o), 1);

      // reset asserted mid-frame with banks 0 and 2 occupied
      @(posedge clk); #1; in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1; flush_done = 1'b0;
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); #1; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      @(negedge clk);
      chk("pre_reset_vld", int'(stage_vld_o), 5);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("mid_rst");
      @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b1;

      // random frames with stalls, gaps and stray flush_done
      for (int f = 0; f < 8; f++)
         run_frame(int'($urandom_range(10, 1)), 70, 70, 30, t0, fs, fd);

      // six-symbol frame: 2-bit counter saturates
      run_frame(6, 80, 80, 50, t0, fs, fd);
      chk("six_sym_count",    int'(sym_count_o), 6);
      chk("six_sym_count_w2", int'(sym_count2),  3);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
